// File: rtl/cd_host_regs_pkg.sv
// -----------------------------------------------------------------------------
// cd_host_regs_pkg
// Shared definitions for the CD host register block: register byte offsets
// within the host window, HIRQ bit positions, CR reset contents and the
// command FSM state encoding.
// -----------------------------------------------------------------------------
package cd_host_regs_pkg;

  // Byte offsets inside the CD register window (host drives A[6:1]).
  localparam logic [6:0] HIRQ_OFS     = 7'h08;
  localparam logic [6:0] HIRQMASK_OFS = 7'h0C;
  localparam logic [6:0] CR_BASE_OFS  = 7'h18;

  // HIRQ bit indices.
  localparam int CMOK_BIT = 0;
  localparam int SCDQ_BIT = 10;

  localparam logic [15:0] HIRQMASK_RST = 16'hFFFF;

  // CR power-up contents ("CDBLOCK" signature); CRs past CR4 reset to zero.
  localparam logic [15:0] CR1_RST = 16'h0043;
  localparam logic [15:0] CR2_RST = 16'h4442;
  localparam logic [15:0] CR3_RST = 16'h4C4F;
  localparam logic [15:0] CR4_RST = 16'h434B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } cd_state_e;

  // Reset value of CR(k+1), k zero-based.
  function automatic logic [15:0] cr_rst_val(input int k);
    case (k)
      0:       return CR1_RST;
      1:       return CR2_RST;
      2:       return CR3_RST;
      3:       return CR4_RST;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/cd_host_regs_rpt_timer.sv
// -----------------------------------------------------------------------------
// cd_rpt_timer
// Periodic status report counter. Counts clock-enabled ticks while enabled and
// pulses 'tick' on the tick where the count reaches PERIOD-1, wrapping to 0.
// 'clr' forces the count to 0 and suppresses the pulse.
//
// Ports:
//   CLK   in   system clock
//   RST_N in   asynchronous active-low reset
//   ce    in   clock enable
//   en    in   count enable (command FSM idle)
//   clr   in   synchronous clear (command issue / not idle)
//   tick  out  report strobe, combinational, one enabled tick wide
// -----------------------------------------------------------------------------
module cd_rpt_timer
  import cd_host_regs_pkg::*;
#(
  parameter logic [15:0] PERIOD = 16'd1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ce,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [15:0] cnt_q;

  assign tick = ce & en & ~clr & (cnt_q == PERIOD - 16'd1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (ce) begin
      if (clr) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cd_host_regs.sv
// -----------------------------------------------------------------------------
// cd_host_regs
// Host-side register file of the CD block: HIRQ / HIRQMASK interrupt registers,
// N_CR command/response registers, a command handshake towards the drive core
// and periodic status reports while idle.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   CE_R                clock enable; all state advances only when high
//   CS_N, A, DI, WE_N   host bus: select, word offset A[6:1], write data, strobe
//   DO                  host read data (combinational)
//   IRQ_N               host interrupt, active low
//   CMD_VALID/READY     command handshake to the drive core
//   CMD_DATA            CR1..CR(N_CR) captured at issue, CR1 in the MSBs
//   RSP_VALID/RSP_DATA  drive core response, loaded into the CRs while busy
//   STAT_DATA           drive status copied into the CRs by periodic reports
// -----------------------------------------------------------------------------
module cd_host_regs
  import cd_host_regs_pkg::*;
#(
  parameter int          N_CR       = 4,
  parameter logic [15:0] RPT_PERIOD = 16'd1000,
  parameter logic [15:0] HIRQ_RST   = 16'hFFFF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CE_R,
  input  logic                 CS_N,
  input  logic [5:0]           A,
  input  logic [15:0]          DI,
  input  logic                 WE_N,
  output logic [15:0]          DO,
  output logic                 IRQ_N,
  output logic                 CMD_VALID,
  input  logic                 CMD_READY,
  output logic [16*N_CR-1:0]   CMD_DATA,
  input  logic                 RSP_VALID,
  input  logic [16*N_CR-1:0]   RSP_DATA,
  input  logic [16*N_CR-1:0]   STAT_DATA
);

  localparam int CRW = 16 * N_CR;

  logic [15:0]    hirq_q;
  logic [15:0]    hirq_d;
  logic [15:0]    hirqmask_q;
  logic [15:0]    cr_q [N_CR];
  logic [CRW-1:0] cr_pack;
  logic [CRW-1:0] cmd_data_q;
  logic [15:0]    rd_data;
  cd_state_e      state_q;
  cd_state_e      state_d;

  // Address decode. The host presents a word offset; registers are mapped at
  // byte offsets, so rebuild the byte address and derive the CR index.
  logic [6:0] addr;
  logic [6:0] cr_off;
  logic [4:0] cr_idx;
  logic       cr_hit;

  assign addr   = {A, 1'b0};
  assign cr_off = addr - CR_BASE_OFS;
  assign cr_idx = cr_off[6:2];
  assign cr_hit = (addr >= CR_BASE_OFS) && (cr_off[1:0] == 2'b00) &&
                  (int'(cr_idx) < N_CR);

  logic host_wr;
  logic hirq_wr;
  logic mask_wr;
  logic cr_wr;
  logic issue;
  logic rsp_load;
  logic rpt_load;

  assign host_wr  = CE_R && !CS_N && !WE_N;
  assign hirq_wr  = host_wr && (addr == HIRQ_OFS);
  assign mask_wr  = host_wr && (addr == HIRQMASK_OFS);
  assign cr_wr    = host_wr && cr_hit && (state_q == ST_IDLE);
  assign issue    = cr_wr && (int'(cr_idx) == N_CR - 1);
  assign rsp_load = CE_R && RSP_VALID && (state_q == ST_BUSY);

  // Clearing on the issue cycle both restarts the count for the next idle
  // period and drops a report that would coincide with the host command.
  cd_rpt_timer #(
    .PERIOD (RPT_PERIOD)
  ) u_rpt_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .ce    (CE_R),
    .en    (state_q == ST_IDLE),
    .clr   (issue || (state_q != ST_IDLE)),
    .tick  (rpt_load)
  );

  always_comb begin
    cr_pack = '0;
    for (int k = 0; k < N_CR; k++) begin
      cr_pack[CRW-1-16*k -: 16] = cr_q[k];
    end
  end

  // Host AND first, hardware sets last so a set wins on its own bit.
  always_comb begin
    hirq_d = hirq_q;
    if (hirq_wr)  hirq_d = hirq_q & DI;
    if (issue)    hirq_d[CMOK_BIT] = 1'b0;
    if (rsp_load) hirq_d[CMOK_BIT] = 1'b1;
    if (rpt_load) hirq_d[SCDQ_BIT] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (issue)                state_d = ST_ISSUE;
      ST_ISSUE: if (CE_R && CMD_READY)    state_d = ST_BUSY;
      ST_BUSY:  if (rsp_load)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hirq_q     <= HIRQ_RST;
      hirqmask_q <= HIRQMASK_RST;
      cmd_data_q <= '0;
      for (int k = 0; k < N_CR; k++) begin
        cr_q[k] <= cr_rst_val(k);
      end
    end else begin
      hirq_q <= hirq_d;
      if (mask_wr) hirqmask_q <= DI;
      // The last CR is being written this cycle, so take it from DI.
      if (issue)   cmd_data_q <= {cr_pack[CRW-1:16], DI};
      for (int k = 0; k < N_CR; k++) begin
        if (cr_wr && (int'(cr_idx) == k)) begin
          cr_q[k] <= DI;
        end else if (rsp_load) begin
          cr_q[k] <= RSP_DATA[CRW-1-16*k -: 16];
        end else if (rpt_load) begin
          cr_q[k] <= STAT_DATA[CRW-1-16*k -: 16];
        end
      end
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (!CS_N) begin
      if (addr == HIRQ_OFS) begin
        rd_data = hirq_q;
      end else if (addr == HIRQMASK_OFS) begin
        rd_data = hirqmask_q;
      end else if (cr_hit) begin
        for (int k = 0; k < N_CR; k++) begin
          if (int'(cr_idx) == k) rd_data = cr_q[k];
        end
      end
    end
  end

  assign DO        = rd_data;
  assign IRQ_N     = ~|(hirq_q & hirqmask_q);
  assign CMD_VALID = (state_q == ST_ISSUE);
  assign CMD_DATA  = cmd_data_q;

endmodule

// File: tb/tb_cd_host_regs.sv
// -----------------------------------------------------------------------------
// tb_cd_host_regs
// Directed bench for cd_host_regs. Two instances share all inputs: u_dut uses
// a long report period so reports never disturb the register/command tests,
// u_rpt uses RPT_PERIOD=4 for the report timer tests.
// -----------------------------------------------------------------------------
module tb_cd_host_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_r;
  logic        cs_n;
  logic [5:0]  a_bus;
  logic [15:0] di;
  logic        we_n;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [63:0] stat_data;

  logic [15:0] do_m, do_r;
  logic        irq_n_m, irq_n_r;
  logic        cmd_valid_m, cmd_valid_r;
  logic [63:0] cmd_data_m, cmd_data_r;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cd_host_regs #(.N_CR(4), .RPT_PERIOD(16'd1000), .HIRQ_RST(16'hFFFF)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CS_N(cs_n), .A(a_bus), .DI(di),
    .WE_N(we_n), .DO(do_m), .IRQ_N(irq_n_m), .CMD_VALID(cmd_valid_m),
    .CMD_READY(cmd_ready), .CMD_DATA(cmd_data_m), .RSP_VALID(rsp_valid),
    .RSP_DATA(rsp_data), .STAT_DATA(stat_data)
  );

  cd_host_regs #(.N_CR(4), .RPT_PERIOD(16'd4), .HIRQ_RST(16'hFFFF)) u_rpt (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CS_N(cs_n), .A(a_bus), .DI(di),
    .WE_N(we_n), .DO(do_r), .IRQ_N(irq_n_r), .CMD_VALID(cmd_valid_r),
    .CMD_READY(cmd_ready), .CMD_DATA(cmd_data_r), .RSP_VALID(rsp_valid),
    .RSP_DATA(rsp_data), .STAT_DATA(stat_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    a_bus = a[6:1];
    di    = d;
    cs_n  = 1'b0;
    we_n  = 1'b0;
    step();
    cs_n  = 1'b1;
    we_n  = 1'b1;
  endtask

  task automatic rd(input logic [6:0] a, output logic [15:0] dmain, output logic [15:0] drpt);
    a_bus = a[6:1];
    cs_n  = 1'b0;
    we_n  = 1'b1;
    #1;
    dmain = do_m;
    drpt  = do_r;
    cs_n  = 1'b1;
  endtask

  logic [15:0] dm, dr;
  logic [7:0]  load_mask;
  int          busy_loads;
  logic        any_valid;

  initial begin
    cs_n = 1'b1; we_n = 1'b1; a_bus = '0; di = '0; ce_r = 1'b1;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; stat_data = '0;
    rst_n = 1'b0;
    step(); step();
    check("rst_cmd_valid", cmd_valid_m, 1'b0);
    rst_n = 1'b1;

    // Reset contents
    rd(7'h18, dm, dr); check("rst_cr1", dm, 16'h0043);
    rd(7'h1C, dm, dr); check("rst_cr2", dm, 16'h4442);
    rd(7'h20, dm, dr); check("rst_cr3", dm, 16'h4C4F);
    rd(7'h24, dm, dr); check("rst_cr4", dm, 16'h434B);
    rd(7'h08, dm, dr); check("rst_hirq", dm, 16'hFFFF);
    rd(7'h0C, dm, dr); check("rst_mask", dm, 16'hFFFF);
    check("rst_irq_n", irq_n_m, 1'b0);
    check("rst_cmd_data", cmd_data_m, 64'h0);
    rd(7'h10, dm, dr); check("unmapped_rd", dm, 16'h0000);

    // HIRQ / HIRQMASK behaviour
    ce_r = 1'b0;
    wr(7'h18, 16'hDEAD);
    ce_r = 1'b1;
    rd(7'h18, dm, dr); check("ce_gate", dm, 16'h0043);
    wr(7'h08, 16'hFF0F);
    rd(7'h08, dm, dr); check("hirq_and", dm, 16'hFF0F);
    wr(7'h0C, 16'h0001);
    rd(7'h0C, dm, dr); check("mask_wr", dm, 16'h0001);
    check("irq_masked_on", irq_n_m, 1'b0);
    wr(7'h08, 16'h0000);
    rd(7'h08, dm, dr); check("hirq_clr", dm, 16'h0000);
    check("irq_off", irq_n_m, 1'b1);
    wr(7'h08, 16'hFFFF);
    rd(7'h08, dm, dr); check("hirq_ones_noop", dm, 16'h0000);
    wr(7'h10, 16'h1234);
    rd(7'h10, dm, dr); check("unmapped_wr", dm, 16'h0000);

    // Command / response round trip
    rsp_data = 64'hDEAD_DEAD_DEAD_DEAD; rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
    rd(7'h18, dm, dr); check("rsp_idle_ignored", dm, 16'h0043);
    wr(7'h18, 16'h1000);
    wr(7'h1C, 16'h0000);
    wr(7'h20, 16'h0000);
    check("no_early_issue", cmd_valid_m, 1'b0);
    rd(7'h18, dm, dr); check("cr1_wr", dm, 16'h1000);
    wr(7'h24, 16'h0000);
    check("issue_valid", cmd_valid_m, 1'b1);
    wr(7'h18, 16'hBEEF);
    check("ready_lo_1", cmd_valid_m, 1'b1);
    step(); check("ready_lo_2", cmd_valid_m, 1'b1);
    step(); check("ready_lo_3", cmd_valid_m, 1'b1);
    check("issue_data", cmd_data_m, 64'h1000_0000_0000_0000);
    rd(7'h18, dm, dr); check("cr_wr_issue_ign", dm, 16'h1000);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("valid_drop", cmd_valid_m, 1'b0);
    wr(7'h1C, 16'h5555);
    rd(7'h1C, dm, dr); check("cr_wr_busy_ign", dm, 16'h0000);
    step();
    rsp_data = 64'h2000_0001_0002_0003; rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
    rd(7'h18, dm, dr); check("rsp_cr1", dm, 16'h2000);
    rd(7'h1C, dm, dr); check("rsp_cr2", dm, 16'h0001);
    rd(7'h20, dm, dr); check("rsp_cr3", dm, 16'h0002);
    rd(7'h24, dm, dr); check("rsp_cr4", dm, 16'h0003);
    rd(7'h08, dm, dr); check("rsp_cmok", dm, 16'h0001);
    check("rsp_irq_n", irq_n_m, 1'b0);

    // Host HIRQ clear colliding with response set
    wr(7'h24, 16'h0007);
    check("issue2_valid", cmd_valid_m, 1'b1);
    check("issue2_data", cmd_data_m, 64'h2000_0001_0002_0007);
    rd(7'h08, dm, dr); check("cmok_clear", dm, 16'h0000);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    a_bus = 6'h04; di = 16'h0000; cs_n = 1'b0; we_n = 1'b0;
    rsp_data = 64'h0A0B_0C0D_0E0F_0001; rsp_valid = 1'b1;
    step();
    cs_n = 1'b1; we_n = 1'b1; rsp_valid = 1'b0;
    rd(7'h08, dm, dr); check("hirq_set_wins", dm, 16'h0001);
    rd(7'h18, dm, dr); check("rsp2_cr1", dm, 16'h0A0B);

    // Periodic reports (u_rpt, period 4)
    rst_n = 1'b0; #1; rst_n = 1'b1;
    wr(7'h08, 16'h0000);
    rd(7'h08, dm, dr); check("rpt_hirq_clr", dr, 16'h0000);
    load_mask = '0;
    a_bus = 6'h0C; cs_n = 1'b0; we_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      stat_data = {16'h5A00 + 16'(t), 16'h1111, 16'h2222, 16'h3333};
      step();
      if (do_r == 16'h5A00 + 16'(t)) load_mask[t-1] = 1'b1;
    end
    cs_n = 1'b1;
    check("rpt_load_ticks", load_mask, 8'h44);
    rd(7'h18, dm, dr); check("rpt_cr1", dr, 16'h5A07);
    rd(7'h24, dm, dr); check("rpt_cr4", dr, 16'h3333);
    rd(7'h08, dm, dr); check("rpt_scdq", dr, 16'h0400);
    check("rpt_irq_n", irq_n_r, 1'b0);
    wr(7'h08, 16'h0000);
    wr(7'h24, 16'h0000);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("rpt_busy_valid", cmd_valid_r, 1'b0);
    busy_loads = 0;
    a_bus = 6'h0C; cs_n = 1'b0; we_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      stat_data = {16'h7700 + 16'(t), 16'h4444, 16'h5555, 16'h6666};
      step();
      if (do_r == 16'h7700 + 16'(t)) busy_loads++;
    end
    cs_n = 1'b1;
    check("busy_no_loads", busy_loads, 0);
    rd(7'h18, dm, dr); check("busy_cr1_hold", dr, 16'h5A07);
    rd(7'h08, dm, dr); check("busy_no_scdq", dr, 16'h0000);

    // Reset during BUSY
    rst_n = 1'b0; #1;
    check("abort_valid", cmd_valid_m, 1'b0);
    rd(7'h08, dm, dr); check("abort_hirq", dm, 16'hFFFF);
    rd(7'h0C, dm, dr); check("abort_mask", dm, 16'hFFFF);
    rd(7'h18, dm, dr); check("abort_cr1", dm, 16'h0043);
    rd(7'h24, dm, dr); check("abort_cr4", dm, 16'h434B);
    check("abort_cmd_data", cmd_data_m, 64'h0);
    step();
    rst_n = 1'b1;
    any_valid = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_valid_m || cmd_valid_r) any_valid = 1'b1;
    end
    cmd_ready = 1'b0;
    check("abort_no_valid", any_valid, 1'b0);
    wr(7'h18, 16'h1111);
    rd(7'h18, dm, dr); check("abort_idle", dm, 16'h1111);

    // Host command coinciding with a report tick (u_rpt)
    rst_n = 1'b0; #1; rst_n = 1'b1;
    stat_data = 64'hEEEE_EEEE_EEEE_EEEE;
    wr(7'h08, 16'h0000);
    step();
    step();
    wr(7'h24, 16'h9999);
    check("coll_valid", cmd_valid_r, 1'b1);
    check("coll_data", cmd_data_r, 64'h0043_4442_4C4F_9999);
    rd(7'h08, dm, dr); check("coll_no_scdq", dr, 16'h0000);
    rd(7'h18, dm, dr); check("coll_no_load", dr, 16'h0043);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
